// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: width codes, owner ids and FSM states.
// Also holds the fixed-priority selection rule so every user agrees on it.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    WIDTH_BYTE   = 3'b000,
    WIDTH_HALF   = 3'b001,
    WIDTH_WORD   = 3'b010,
    WIDTH_BYTE_U = 3'b100,
    WIDTH_HALF_U = 3'b101
  } width_e;

  typedef enum logic {
    OWNER_IMEM = 1'b0,
    OWNER_DMEM = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Data port wins unless fetch is waiting and has been passed over too often.
  function automatic owner_e pick_owner(input logic imem_vld,
                                        input logic dmem_vld,
                                        input logic starved);
    if (dmem_vld && !(imem_vld && starved)) begin
      return OWNER_DMEM;
    end
    return OWNER_IMEM;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and data ports, one transaction in flight.
// Request accepted combinationally with mem_req_ready; response routed to the owner the same cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              imem_req_valid,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_req_ready,
  output logic              imem_resp_valid,
  output logic [DATA_W-1:0] imem_resp_data,

  input  logic              dmem_req_valid,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic              dmem_req_write_enable,
  input  logic [DATA_W-1:0] dmem_req_write_data,
  input  logic [2:0]        dmem_req_data_width,
  output logic              dmem_req_ready,
  output logic              dmem_resp_valid,
  output logic [DATA_W-1:0] dmem_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_write_enable,
  output logic [DATA_W-1:0] mem_req_write_data,
  output logic [2:0]        mem_req_data_width,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,

  output logic              busy,
  output logic              owner
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  owner_e              sel_q, sel_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  owner_e sel_cur;
  logic   starved;
  logic   any_vld;
  logic   req_vld;
  logic   accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= OWNER_IMEM;
      owner_q  <= OWNER_IMEM;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Selection is only live in IDLE; once a request is shown it stays locked in sel_q.
  always_comb begin
    starved = (streak_q == STREAK_MAX);
    any_vld = imem_req_valid | dmem_req_valid;
    sel_cur = (state_q == ST_HOLD) ? sel_q
                                   : pick_owner(imem_req_valid, dmem_req_valid, starved);
    req_vld = ((state_q == ST_IDLE) && any_vld) || (state_q == ST_HOLD);
    accept  = req_vld && mem_req_ready;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sel_d   = sel_cur;
          owner_d = sel_cur;
          state_d = ST_WAIT;
        end else if (req_vld) begin
          sel_d   = sel_cur;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          owner_d = sel_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A cycle without a fetch request forgives any streak, even one where dmem is granted.
  always_comb begin
    streak_d = streak_q;
    if (!imem_req_valid) begin
      streak_d = '0;
    end else if (accept && (sel_cur == OWNER_IMEM)) begin
      streak_d = '0;
    end else if (accept && (sel_cur == OWNER_DMEM) && !starved) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_comb begin
    mem_req_valid        = 1'b0;
    mem_req_addr         = '0;
    mem_req_write_enable = 1'b0;
    mem_req_write_data   = '0;
    mem_req_data_width   = 3'b000;
    imem_req_ready       = 1'b0;
    dmem_req_ready       = 1'b0;
    imem_resp_valid      = 1'b0;
    imem_resp_data       = '0;
    dmem_resp_valid      = 1'b0;
    dmem_resp_data       = '0;
    busy                 = 1'b0;
    if (!reset) begin
      busy          = (state_q != ST_IDLE);
      mem_req_valid = req_vld;
      if (req_vld) begin
        if (sel_cur == OWNER_DMEM) begin
          mem_req_addr         = dmem_req_addr;
          mem_req_write_enable = dmem_req_write_enable;
          mem_req_write_data   = dmem_req_write_data;
          mem_req_data_width   = dmem_req_data_width;
          dmem_req_ready       = accept;
        end else begin
          mem_req_addr         = imem_req_addr;
          mem_req_data_width   = WIDTH_WORD;
          imem_req_ready       = accept;
        end
      end
      // Responses outside WAIT belong to an abandoned transaction and are dropped.
      if ((state_q == ST_WAIT) && mem_resp_valid) begin
        if (owner_q == OWNER_DMEM) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_data  = mem_resp_data;
        end else begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_resp_data;
        end
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester/memory models feed expected grants and responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct { bit port; logic [31:0] addr; bit we; } gnt_t;
  typedef struct { bit port; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; logic [2:0] width; } dreq_t;

  logic        clk;
  logic        reset;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        dmem_req_valid, dmem_req_write_enable, dmem_req_ready, dmem_resp_valid;
  logic [31:0] dmem_req_addr, dmem_req_write_data, dmem_resp_data;
  logic [2:0]  dmem_req_data_width;
  logic        mem_req_valid, mem_req_ready, mem_req_write_enable, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_write_data, mem_resp_data;
  logic [2:0]  mem_req_data_width;
  logic        busy, owner;

  gnt_t        exp_g[$];
  rsp_t        exp_r[$];
  logic [31:0] iq[$];
  dreq_t       dq[$];
  int          gcyc[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mem_hold = 0;
  bit          force_resp = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
    .dmem_req_write_enable(dmem_req_write_enable), .dmem_req_write_data(dmem_req_write_data),
    .dmem_req_data_width(dmem_req_data_width), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write_enable(mem_req_write_enable),
    .mem_req_write_data(mem_req_write_data), .mem_req_data_width(mem_req_data_width),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .owner(owner)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_grant(input bit port, input logic [31:0] addr, input bit we,
                           input logic [31:0] data);
    gnt_t g;
    rsp_t r;
    g.port = port; g.addr = addr; g.we = we;
    r.port = port; r.data = data;
    exp_g.push_back(g);
    exp_r.push_back(r);
  endtask

  task automatic push_d(input logic [31:0] addr, input bit we, input logic [31:0] wd);
    dreq_t d;
    d.addr = addr; d.we = we; d.wdata = wd; d.width = WIDTH_WORD;
    dq.push_back(d);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_g.size() != 0 || exp_r.size() != 0 || iq.size() != 0 || dq.size() != 0)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_g.size() != 0 || exp_r.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d grants and %0d responses still pending, required 0",
               name, exp_g.size(), exp_r.size());
      exp_g.delete(); exp_r.delete(); iq.delete(); dq.delete();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Requester models: hold valid and fields until the ready seen on the previous cycle pops them.
  initial begin
    bit ia, da;
    imem_req_valid = 0; imem_req_addr = 0;
    dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_write_enable = 0;
    dmem_req_write_data = 0; dmem_req_data_width = 0;
    forever begin
      @(negedge clk);
      ia = imem_req_ready;
      da = dmem_req_ready;
      @(posedge clk);
      #1;
      if (ia && iq.size() != 0) void'(iq.pop_front());
      if (da && dq.size() != 0) void'(dq.pop_front());
      imem_req_valid = (iq.size() != 0);
      imem_req_addr  = (iq.size() != 0) ? iq[0] : 32'h0;
      dmem_req_valid = (dq.size() != 0);
      if (dq.size() != 0) begin
        dmem_req_addr         = dq[0].addr;
        dmem_req_write_enable = dq[0].we;
        dmem_req_write_data   = dq[0].wdata;
        dmem_req_data_width   = dq[0].width;
      end else begin
        dmem_req_addr = 0; dmem_req_write_enable = 0;
        dmem_req_write_data = 0; dmem_req_data_width = 0;
      end
    end
  end

  // Memory model: one-cycle response to each accepted request unless held off.
  initial begin
    bit          acc, we;
    logic [31:0] a, wd;
    mem_resp_valid = 0;
    mem_resp_data  = 0;
    forever begin
      @(negedge clk);
      acc = mem_req_valid && mem_req_ready && !reset;
      a   = mem_req_addr;
      we  = mem_req_write_enable;
      wd  = mem_req_write_data;
      @(posedge clk);
      #1;
      if (acc && we) mem_arr[a] = wd;
      mem_resp_valid = (acc && !mem_hold) || force_resp;
      if (acc && !mem_hold && !we) mem_resp_data = rd_word(a);
      else if (force_resp)         mem_resp_data = 32'hBAD0BAD0;
      else                         mem_resp_data = 32'h0;
    end
  end

  // Monitor: compares every grant and every response against the scoreboard queues.
  initial begin
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (mem_req_valid && mem_req_ready) begin
          checks++;
          if (imem_req_ready == dmem_req_ready) begin
            errors++;
            $display("FAIL grant_ready: imem_ready %0b dmem_ready %0b, required exactly one",
                     imem_req_ready, dmem_req_ready);
          end else if (exp_g.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: port %0b addr %h, required no grant",
                     dmem_req_ready, mem_req_addr);
          end else begin
            g = exp_g.pop_front();
            gcyc.push_back(cyc);
            if (dmem_req_ready != g.port || mem_req_addr != g.addr ||
                mem_req_write_enable != g.we) begin
              errors++;
              $display("FAIL grant: port %0b addr %h we %0b, required port %0b addr %h we %0b",
                       dmem_req_ready, mem_req_addr, mem_req_write_enable,
                       g.port, g.addr, g.we);
            end
          end
        end
        if (imem_resp_valid || dmem_resp_valid) begin
          checks++;
          if (exp_r.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: imem_v %0b dmem_v %0b, required none",
                     imem_resp_valid, dmem_resp_valid);
          end else begin
            r = exp_r.pop_front();
            if ((imem_resp_valid && dmem_resp_valid) || dmem_resp_valid != r.port ||
                (r.port ? dmem_resp_data : imem_resp_data) != r.data ||
                (r.port ? imem_resp_data : dmem_resp_data) != 32'h0) begin
              errors++;
              $display("FAIL resp: imem %0b/%h dmem %0b/%h, required port %0b data %h",
                       imem_resp_valid, imem_resp_data, dmem_resp_valid, dmem_resp_data,
                       r.port, r.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    int    di, ii;
    mem_arr[32'h10] = 32'h00500093;
    reset = 1;
    mem_req_ready = 1;

    // Reset with both ports requesting; dmem store must win first, then the fetch.
    push_d(32'h100, 1'b1, 32'hDEADBEEF);
    iq.push_back(32'h10);
    exp_grant(1'b1, 32'h100, 1'b1, 32'h0);
    exp_grant(1'b0, 32'h10, 1'b0, 32'h00500093);
    @(posedge clk); #2;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
      chk("rst_readies", {30'b0, imem_req_ready, dmem_req_ready}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
    end
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_owner", {31'b0, owner}, 32'h0);
    @(posedge clk); #2;
    reset = 0;
    gcyc.delete();
    drain("contention", 40);
    if (gcyc.size() == 2) chk("contention_gap", gcyc[1] - gcyc[0], 32'd2);
    else chk("contention_grants", gcyc.size(), 32'd2);

    // Single fetch on its own.
    iq.push_back(32'h10);
    exp_grant(1'b0, 32'h10, 1'b0, 32'h00500093);
    drain("single_fetch", 20);

    // Starvation guard: four data grants then one fetch while both keep requesting.
    gcyc.delete();
    pat = "ddddiddddiddi";
    di = 0; ii = 0;
    for (int k = 0; k < 10; k++) push_d(32'h200 + 32'(4 * k), 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) iq.push_back(32'h20 + 32'(4 * k));
    for (int k = 0; k < pat.len(); k++) begin
      if (pat[k] == "d") begin
        exp_grant(1'b1, 32'h200 + 32'(4 * di), 1'b0, {16'hC0DE, 16'h0200 + 16'(4 * di)});
        di++;
      end else begin
        exp_grant(1'b0, 32'h20 + 32'(4 * ii), 1'b0, {16'hC0DE, 16'h0020 + 16'(4 * ii)});
        ii++;
      end
    end
    drain("starvation", 80);
    if (gcyc.size() == 13) chk("starve_rate", gcyc[12] - gcyc[0], 32'd24);
    else chk("starve_grants", gcyc.size(), 32'd13);

    // Backpressure: dmem request held in HOLD while the fetch port starts requesting.
    mem_req_ready = 0;
    push_d(32'h300, 1'b0, 32'h0);
    exp_grant(1'b1, 32'h300, 1'b0, 32'hC0DE0300);
    exp_grant(1'b0, 32'h30, 1'b0, 32'hC0DE0030);
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_valid", {31'b0, mem_req_valid}, 32'h1);
    chk("bp_idle_addr", mem_req_addr, 32'h300);
    chk("bp_idle_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #2;
    iq.push_back(32'h30);
    @(negedge clk);
    chk("bp_hold_busy", {31'b0, busy}, 32'h1);
    chk("bp_hold_addr", mem_req_addr, 32'h300);
    @(negedge clk);
    chk("bp_hold_imem_vld", {31'b0, imem_req_valid}, 32'h1);
    chk("bp_hold_addr2", mem_req_addr, 32'h300);
    chk("bp_hold_imem_rdy", {31'b0, imem_req_ready}, 32'h0);
    chk("bp_hold_valid", {31'b0, mem_req_valid}, 32'h1);
    @(posedge clk); #2;
    mem_req_ready = 1;
    drain("backpressure", 30);

    // Reset during WAIT, then a stale response that must not reach either port.
    mem_hold = 1;
    iq.push_back(32'h40);
    begin
      gnt_t g;
      g.port = 1'b0; g.addr = 32'h40; g.we = 1'b0;
      exp_g.push_back(g);
    end
    for (int n = 0; n < 20 && exp_g.size() != 0; n++) @(negedge clk);
    @(posedge clk); #2;
    chk("wait_busy", {31'b0, busy}, 32'h1);
    chk("wait_owner", {31'b0, owner}, 32'h0);
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #2;
    reset = 0;
    mem_hold = 0;
    force_resp = 1;
    @(posedge clk); #2;
    force_resp = 0;
    @(negedge clk);
    chk("stale_resp_valid", {31'b0, mem_resp_valid}, 32'h1);
    chk("stale_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    iq.push_back(32'h10);
    exp_grant(1'b0, 32'h10, 1'b0, 32'h00500093);
    drain("after_reset", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
